// File: rtl/id_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// id_hazard_ctrl_if
// Groups the ID/EXE/MEM status signals seen by the hazard controller and the
// freeze/flush/monitor signals it returns.
//   master : pipeline side (drives register ids, enables, memory handshake)
//   slave  : id_hazard_ctrl (drives freeze/flush controls, flags, counters)
// Parameters:
//   REG_FILE_ADDR_LEN : register address width
//   CNT_W             : width of the performance counters
// ---------------------------------------------------------------------------
interface id_hazard_ctrl_if #(
   parameter int unsigned REG_FILE_ADDR_LEN = 5,
   parameter int unsigned CNT_W             = 16
);

   // ID stage
   logic [REG_FILE_ADDR_LEN-1:0] src1;
   logic [REG_FILE_ADDR_LEN-1:0] src2;
   logic                         is_imm;
   logic                         st_or_bne;
   logic                         br_taken;

   // EXE stage
   logic [REG_FILE_ADDR_LEN-1:0] exe_dest;
   logic                         exe_wb_en;
   logic                         exe_mem_r_en;

   // MEM stage and data-memory handshake
   logic [REG_FILE_ADDR_LEN-1:0] mem_dest;
   logic                         mem_wb_en;
   logic                         mem_req;
   logic                         mem_ready;

   // Controller results
   logic                         hazard_detected;
   logic                         pc_freeze;
   logic                         ifid_freeze;
   logic                         ifid_flush;
   logic                         back_freeze;
   logic                         mem_timeout;
   logic [CNT_W-1:0]             stall_cnt;
   logic [CNT_W-1:0]             flush_cnt;

   modport master (
      output src1, src2, is_imm, st_or_bne, br_taken,
      output exe_dest, exe_wb_en, exe_mem_r_en,
      output mem_dest, mem_wb_en, mem_req, mem_ready,
      input  hazard_detected, pc_freeze, ifid_freeze, ifid_flush, back_freeze,
      input  mem_timeout, stall_cnt, flush_cnt
   );

   modport slave (
      input  src1, src2, is_imm, st_or_bne, br_taken,
      input  exe_dest, exe_wb_en, exe_mem_r_en,
      input  mem_dest, mem_wb_en, mem_req, mem_ready,
      output hazard_detected, pc_freeze, ifid_freeze, ifid_flush, back_freeze,
      output mem_timeout, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/id_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// id_hazard_ctrl
// Pipeline sequencing controller beside the ID stage. Every cycle it decides
// whether the front end advances, stalls on a read-after-write hazard, stalls
// the whole pipe for an outstanding data-memory access, or flushes IF/ID on
// a taken branch. Keeps saturating stall/flush counters and a sticky memory
// timeout flag.
//
// Ports:
//   clk  : clock, all state updates on rising edge
//   rst  : synchronous active-high reset
//   bus  : id_hazard_ctrl_if.slave (ID/EXE/MEM status in, controls out)
//          hazard_detected, pc_freeze, ifid_freeze, ifid_flush, back_freeze
//          are combinational from inputs and state; mem_timeout, stall_cnt,
//          flush_cnt are registered.
// Parameters:
//   REG_FILE_ADDR_LEN : register address width (must match bus)
//   MAX_WAIT          : memory-wait cycles before mem_timeout (>= 2)
//   CNT_W             : performance counter width (must match bus)
// Build option:
//   ID_HAZARD_FORWARDING_EN : forwarding unit present, only load-use stalls.
//                             Undefined: any EXE/MEM producer stalls.
// The datapath width does not affect this block.
// ---------------------------------------------------------------------------
module id_hazard_ctrl #(
   parameter int unsigned REG_FILE_ADDR_LEN = 5,
   parameter int unsigned MAX_WAIT          = 64,
   parameter int unsigned CNT_W             = 16
) (
   input  logic            clk,
   input  logic            rst,
   id_hazard_ctrl_if.slave bus
);

   localparam int unsigned WCNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MAX_WAIT - 1);
   // wcnt value in the cycle whose update makes it reach MAX_WAIT-1
   localparam logic [WCNT_W-1:0] WCNT_TRIP = WCNT_W'(MAX_WAIT - 2);
   localparam logic [REG_FILE_ADDR_LEN-1:0] REG_ZERO = '0;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [WCNT_W-1:0]   wcnt;
   logic                mem_timeout_q;
   logic [CNT_W-1:0]    stall_cnt_q;
   logic [CNT_W-1:0]    flush_cnt_q;

   logic                use1;
   logic                use2;
   logic                raw;

   logic                hazard_c;
   logic                pc_freeze_c;
   logic                ifid_freeze_c;
   logic                ifid_flush_c;
   logic                back_freeze_c;

   // Which ID sources are actually read; register 0 never creates a hazard.
   assign use1 = (bus.src1 != REG_ZERO);
   assign use2 = (bus.src2 != REG_ZERO) && (!bus.is_imm || bus.st_or_bne);

`ifdef ID_HAZARD_FORWARDING_EN
   logic m_exe1;
   logic m_exe2;

   // Forwarding covers ALU results; only a load in EXE must stall one cycle.
   assign m_exe1 = bus.exe_wb_en && (bus.exe_dest == bus.src1);
   assign m_exe2 = bus.exe_wb_en && (bus.exe_dest == bus.src2);
   assign raw    = bus.exe_mem_r_en && ((use1 && m_exe1) || (use2 && m_exe2));
`else
   logic m_exe1;
   logic m_exe2;
   logic m_mem1;
   logic m_mem2;

   // No forwarding: any pending writer in EXE or MEM blocks the reader.
   assign m_exe1 = bus.exe_wb_en && (bus.exe_dest == bus.src1);
   assign m_exe2 = bus.exe_wb_en && (bus.exe_dest == bus.src2);
   assign m_mem1 = bus.mem_wb_en && (bus.mem_dest == bus.src1);
   assign m_mem2 = bus.mem_wb_en && (bus.mem_dest == bus.src2);
   assign raw    = (use1 && (m_exe1 || m_mem1)) || (use2 && (m_exe2 || m_mem2));
`endif

   // Next state and control decode; priority is memory wait > RAW > branch.
   always_comb begin
      state_nxt     = state;
      hazard_c      = 1'b0;
      pc_freeze_c   = 1'b0;
      ifid_freeze_c = 1'b0;
      ifid_flush_c  = 1'b0;
      back_freeze_c = 1'b0;
      case (state)
         ST_RUN: begin
            if (bus.mem_req && !bus.mem_ready) begin
               state_nxt     = ST_MEM_WAIT;
               pc_freeze_c   = 1'b1;
               ifid_freeze_c = 1'b1;
               back_freeze_c = 1'b1;
            end else if (raw) begin
               // back end keeps moving so the bubble enters EXE
               hazard_c      = 1'b1;
               pc_freeze_c   = 1'b1;
               ifid_freeze_c = 1'b1;
            end else if (bus.br_taken) begin
               ifid_flush_c  = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            // completion cycle releases the pipe; branches are re-presented
            // by ID afterwards, so no flush here
            if (bus.mem_ready) begin
               state_nxt     = ST_RUN;
            end else begin
               pc_freeze_c   = 1'b1;
               ifid_freeze_c = 1'b1;
               back_freeze_c = 1'b1;
            end
         end
         default: begin
            state_nxt = ST_RUN;
         end
      endcase
   end

   // State, wait counter, sticky timeout and saturating performance counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_RUN;
         wcnt          <= '0;
         mem_timeout_q <= 1'b0;
         stall_cnt_q   <= '0;
         flush_cnt_q   <= '0;
      end else begin
         state <= state_nxt;

         if ((state == ST_MEM_WAIT) && !bus.mem_ready) begin
            if (wcnt != WCNT_LAST) begin
               wcnt <= wcnt + WCNT_W'(1);
            end
            if (wcnt == WCNT_TRIP) begin
               mem_timeout_q <= 1'b1;
            end
         end else begin
            wcnt <= '0;
         end

         if (pc_freeze_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
         if (ifid_flush_c && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         end
      end
   end

   assign bus.hazard_detected = hazard_c;
   assign bus.pc_freeze       = pc_freeze_c;
   assign bus.ifid_freeze     = ifid_freeze_c;
   assign bus.ifid_flush      = ifid_flush_c;
   assign bus.back_freeze     = back_freeze_c;
   assign bus.mem_timeout     = mem_timeout_q;
   assign bus.stall_cnt       = stall_cnt_q;
   assign bus.flush_cnt       = flush_cnt_q;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_id_hazard_ctrl
// Directed stimulus for id_hazard_ctrl with MAX_WAIT = 4 and CNT_W = 4.
// Each driven cycle pushes its hand-computed expected controls onto a queue;
// a negedge monitor pops and compares against the DUT.
// Expected output bits are {hazard_detected, pc_freeze, ifid_freeze,
// ifid_flush, back_freeze, mem_timeout}.
// ---------------------------------------------------------------------------
module tb_id_hazard_ctrl;

   localparam int unsigned AW = 5;
   localparam int unsigned CW = 4;
   localparam int unsigned MW = 4;

`ifdef ID_HAZARD_FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   localparam logic [5:0] O_IDLE  = 6'b000000;
   localparam logic [5:0] O_RAW   = 6'b111000;
   localparam logic [5:0] O_MEM   = 6'b011010;
   localparam logic [5:0] O_FLUSH = 6'b000100;
   localparam logic [5:0] O_TMO   = 6'b000001;

   typedef struct {
      string      name;
      logic [5:0] outs;
      bit         chk_cnt;
      logic [3:0] scnt;
      logic [3:0] fcnt;
   } exp_t;

   logic clk;
   logic rst;
   int   tests;
   int   fails;
   exp_t exp_q[$];

   id_hazard_ctrl_if #(.REG_FILE_ADDR_LEN(AW), .CNT_W(CW)) bus ();

   id_hazard_ctrl #(
      .REG_FILE_ADDR_LEN(AW),
      .MAX_WAIT         (MW),
      .CNT_W            (CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard monitor: one expected entry per driven cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t       e;
         logic [5:0] got;
         e   = exp_q.pop_front();
         got = {bus.hazard_detected, bus.pc_freeze, bus.ifid_freeze,
                bus.ifid_flush, bus.back_freeze, bus.mem_timeout};
         tests++;
         if (got !== e.outs) begin
            fails++;
            $display("FAIL %s ctrl: got %b want %b (ld=%0b)", e.name, got, e.outs,
                     bus.exe_mem_r_en);
         end
         tests++;
         if (bus.ifid_flush === 1'b1 && bus.ifid_freeze === 1'b1) begin
            fails++;
            $display("FAIL %s flush_and_freeze: got flush=1 freeze=1 want not both", e.name);
         end
         if (e.chk_cnt) begin
            tests++;
            if (bus.stall_cnt !== e.scnt || bus.flush_cnt !== e.fcnt) begin
               fails++;
               $display("FAIL %s counters: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                        e.name, bus.stall_cnt, bus.flush_cnt, e.scnt, e.fcnt);
            end
         end
      end
   end

   // Push expectation for the inputs currently applied, then advance a cycle.
   task automatic step(input string nm, input logic [5:0] o, input bit chk,
                       input int sc, input int fc);
      exp_t e;
      e.name    = nm;
      e.outs    = o;
      e.chk_cnt = chk;
      e.scnt    = 4'(sc);
      e.fcnt    = 4'(fc);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.src1         = '0;
      bus.src2         = '0;
      bus.is_imm       = 1'b0;
      bus.st_or_bne    = 1'b0;
      bus.br_taken     = 1'b0;
      bus.exe_dest     = '0;
      bus.exe_wb_en    = 1'b0;
      bus.exe_mem_r_en = 1'b0;
      bus.mem_dest     = '0;
      bus.mem_wb_en    = 1'b0;
      bus.mem_req      = 1'b0;
      bus.mem_ready    = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no end of stimulus want finish before 100us");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tests = 0;
      fails = 0;
      idle();
      rst = 1'b1;
      @(posedge clk);
      #1;
      step("rst_hold", O_IDLE, 1'b0, 0, 0);
      rst = 1'b0;
      step("reset_state", O_IDLE, 1'b1, 0, 0);

      // ALU RAW on src1
      bus.src1 = 5'd3; bus.exe_dest = 5'd3; bus.exe_wb_en = 1'b1;
      step("alu_raw", FWD ? O_IDLE : O_RAW, 1'b0, 0, 0);
      idle();
      step("alu_cnt", O_IDLE, 1'b1, FWD ? 0 : 1, 0);

      // Load-use on src2, then load moves to MEM
      bus.src2 = 5'd5; bus.exe_dest = 5'd5; bus.exe_wb_en = 1'b1; bus.exe_mem_r_en = 1'b1;
      step("load_use", O_RAW, 1'b1, FWD ? 0 : 1, 0);
      idle();
      bus.src2 = 5'd5; bus.mem_dest = 5'd5; bus.mem_wb_en = 1'b1;
      step("load_in_mem", FWD ? O_IDLE : O_RAW, 1'b0, 0, 0);

      // Immediate form does not read src2 unless store/bne
      idle();
      bus.src2 = 5'd5; bus.exe_dest = 5'd5; bus.exe_wb_en = 1'b1; bus.exe_mem_r_en = 1'b1;
      bus.is_imm = 1'b1;
      step("imm_no_src2", O_IDLE, 1'b0, 0, 0);
      bus.st_or_bne = 1'b1;
      step("st_bne_src2", O_RAW, 1'b0, 0, 0);

      // Register 0 never stalls
      idle();
      bus.exe_wb_en = 1'b1; bus.exe_mem_r_en = 1'b1; bus.mem_wb_en = 1'b1;
      step("reg0", O_IDLE, 1'b0, 0, 0);

      // Taken branch, then RAW vs branch priority
      idle();
      bus.br_taken = 1'b1;
      step("branch", O_FLUSH, 1'b0, 0, 0);
      bus.src1 = 5'd7; bus.mem_dest = 5'd7; bus.mem_wb_en = 1'b1;
      step("raw_over_br", FWD ? O_FLUSH : O_RAW, 1'b0, 0, 0);
      idle();
      step("cnt_mix", O_IDLE, 1'b1, FWD ? 2 : 5, FWD ? 2 : 1);

      // Memory wait of 3 cycles with a taken branch held
      rst = 1'b1;
      step("rst_a", O_IDLE, 1'b0, 0, 0);
      rst = 1'b0;
      bus.mem_req = 1'b1; bus.br_taken = 1'b1;
      step("mw_run", O_MEM, 1'b1, 0, 0);
      step("mw_wait1", O_MEM, 1'b0, 0, 0);
      step("mw_wait2", O_MEM, 1'b0, 0, 0);
      bus.mem_ready = 1'b1;
      step("mw_ready", O_IDLE, 1'b1, 3, 0);
      bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
      step("mw_br_after", O_FLUSH, 1'b1, 3, 0);
      idle();
      step("mw_cnt", O_IDLE, 1'b1, 3, 1);

      // Timeout with MAX_WAIT = 4
      bus.mem_req = 1'b1;
      step("to_run", O_MEM, 1'b0, 0, 0);
      step("to_w1", O_MEM, 1'b0, 0, 0);
      step("to_w2", O_MEM, 1'b0, 0, 0);
      step("to_w3", O_MEM, 1'b0, 0, 0);
      step("to_set", O_MEM | O_TMO, 1'b0, 0, 0);
      bus.mem_ready = 1'b1;
      step("to_ready", O_TMO, 1'b0, 0, 0);
      idle();
      step("to_sticky", O_TMO, 1'b1, 8, 1);
      rst = 1'b1;
      step("to_rst", O_TMO, 1'b0, 0, 0);
      rst = 1'b0;
      step("to_clear", O_IDLE, 1'b1, 0, 0);

      // Reset while in MEM_WAIT returns to RUN
      bus.mem_req = 1'b1;
      step("rw_run", O_MEM, 1'b0, 0, 0);
      bus.mem_req = 1'b0;
      rst = 1'b1;
      step("rw_rst", O_MEM, 1'b0, 0, 0);
      rst = 1'b0;
      step("rw_after", O_IDLE, 1'b1, 0, 0);

      // Counter saturation
      bus.br_taken = 1'b1;
      for (int i = 0; i < 20; i++) step("sat_flush", O_FLUSH, 1'b0, 0, 0);
      idle();
      step("sat_fcnt", O_IDLE, 1'b1, 0, 15);
      bus.src1 = 5'd3; bus.exe_dest = 5'd3; bus.exe_wb_en = 1'b1; bus.exe_mem_r_en = 1'b1;
      for (int i = 0; i < 20; i++) step("sat_stall", O_RAW, 1'b0, 0, 0);
      idle();
      step("sat_scnt", O_IDLE, 1'b1, 15, 15);

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/id_hazard_ctrl.md
# id_hazard_ctrl

Pipeline sequencing controller for the 5-stage core. It sits beside the ID stage and decides, every cycle, whether the front end advances, stalls or flushes. It detects read-after-write hazards between the ID-stage sources and the EXE/MEM destinations, and stalls the whole pipeline while a data-memory access is outstanding. It also flushes IF/ID on taken branches and keeps saturating stall and flush counters for performance monitoring.

## Interface
- `N`, 32: datapath width, from `defines`.
- `REG_FILE_ADDR_LEN`, 5: register address width, from `defines`.
- `MAX_WAIT`, 64: memory-wait cycles before `mem_timeout` is raised (≥2).
- `CNT_W`, 16: width of each performance counter.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `src1`  in  REG_FILE_ADDR_LEN  ID source 1 (`instruction[25:21]`).
- `src2`  in  REG_FILE_ADDR_LEN  ID source 2 as read from the register file.
- `is_imm`  in  1  ID instruction uses an immediate; `src2` is not read.
- `st_or_bne`  in  1  ID instruction reads `src2` even though it is an immediate form.
- `br_taken`  in  1  ID resolved a taken branch this cycle.
- `exe_dest`  in  REG_FILE_ADDR_LEN  destination register in EXE.
- `exe_wb_en`  in  1  EXE instruction writes back.
- `exe_mem_r_en`  in  1  EXE instruction is a load.
- `mem_dest`  in  REG_FILE_ADDR_LEN  destination register in MEM.
- `mem_wb_en`  in  1  MEM instruction writes back.
- `mem_req`  in  1  MEM stage issues a load/store this cycle.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `hazard_detected`  out  1  forces ID control signals to zero (bubble).
- `pc_freeze`  out  1  hold PC.
- `ifid_freeze`  out  1  hold the IF/ID register.
- `ifid_flush`  out  1  clear the IF/ID register.
- `back_freeze`  out  1  hold the ID/EXE, EXE/MEM and MEM/WB registers.
- `mem_timeout`  out  1  sticky error flag.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `pc_freeze` = 1.
- `flush_cnt`  out  CNT_W  saturating count of cycles with `ifid_flush` = 1.

## Operation
- Source use:
  - `use1` = (`src1` ≠ 0).
  - `use2` = (`src2` ≠ 0) && (!`is_imm` || `st_or_bne`).
  - Register 0 never causes a hazard.
- Matches:
  - `m_exe(s)` = `exe_wb_en` && `exe_dest` == s.
  - `m_mem(s)` = `mem_wb_en` && `mem_dest` == s.
- RAW condition: see Configuration.
- State machine, two states, RUN and MEM_WAIT; reset state is RUN.
- RUN:
  - If `mem_req` && !`mem_ready`, go to MEM_WAIT. In that same cycle `pc_freeze`, `ifid_freeze` and `back_freeze` are 1.
  - Otherwise, if RAW: `hazard_detected`, `pc_freeze` and `ifid_freeze` are 1; `back_freeze` is 0, so the bubble enters EXE.
  - Otherwise, if `br_taken`: `ifid_flush` is 1.
- MEM_WAIT:
  - `pc_freeze`, `ifid_freeze` and `back_freeze` are 1; `hazard_detected` and `ifid_flush` are 0.
  - Wait counter `wcnt` increments each cycle.
  - On `mem_ready`, return to RUN and clear `wcnt`.
  - If `wcnt` reaches `MAX_WAIT`-1 without `mem_ready`, set `mem_timeout` and remain in MEM_WAIT.
- Priority: memory wait > RAW stall > branch flush.
  - `br_taken` during any stall is ignored.
  - A taken branch is re-presented by ID once the stall releases.
- `ifid_flush` and `ifid_freeze` are never 1 together.
- `stall_cnt` and `flush_cnt` increment on cycles where `pc_freeze` (resp. `ifid_flush`) is 1. They hold at all-ones instead of wrapping.
- `mem_timeout` clears only on `rst`.

## Timing
- Reset: state RUN, `wcnt` = 0, `mem_timeout` = 0, `stall_cnt` = 0, `flush_cnt` = 0.
  - Combinational outputs follow the RUN equations in the same cycle.
- Freeze, flush and `hazard_detected` are combinational from inputs and state, with zero-cycle latency. They take effect at the next `clk` edge.
- Load-use (FORWARDING_EN build) gives exactly one bubble cycle. In the next cycle the load is in MEM and forwarding resolves the hazard.
- Memory access completing with `mem_ready` in the `mem_req` cycle: no stall.
- Access with k wait cycles: freeze is 1 for k cycles. The first of them is in RUN, the remaining k-1 in MEM_WAIT.
- `rst` asserted in MEM_WAIT: return to RUN at the next edge and clear all counters and flags.
- `mem_req` && `mem_ready` while `mem_timeout` is set: return to RUN; `mem_timeout` stays 1.

## Configuration
- `ID_HAZARD_FORWARDING_EN` defined: forwarding unit present.
  - RAW = `exe_mem_r_en` && ((`use1` && `m_exe(src1)`) || (`use2` && `m_exe(src2)`)).
  - Only load-use stalls.
- Not defined: no forwarding.
  - RAW = (`use1` && (`m_exe(src1)` || `m_mem(src1)`)) || (`use2` && (`m_exe(src2)` || `m_mem(src2)`)).
  - `exe_mem_r_en` is ignored.

## Test plan
- ALU RAW: `src1` = 3, `exe_dest` = 3, `exe_wb_en` = 1, `exe_mem_r_en` = 0 → with macro: no stall; without macro: `hazard_detected` = `pc_freeze` = 1 for that cycle, `stall_cnt` +1.
- Load-use, macro defined: `exe_mem_r_en` = 1, `exe_dest` = 5, `src2` = 5, `is_imm` = 0 → exactly one cycle `hazard_detected` = 1. The same case with `is_imm` = 1, `st_or_bne` = 0 → no stall.
- Register 0: `src1` = 0, `exe_dest` = 0, `exe_wb_en` = 1 → no stall in either build.
- Memory wait: `mem_req` = 1, `mem_ready` = 0 for 3 cycles, then 1 → `back_freeze` = 1 for 3 cycles. `br_taken` = 1 held throughout gives `ifid_flush` = 0 during the wait and 1 in the cycle after release. `stall_cnt` = 3.
- Timeout: `MAX_WAIT` = 4, `mem_ready` held 0 → `mem_timeout` = 1 after the 4th wait cycle. It stays 1 after `mem_ready`, and `rst` clears it to 0.
- Saturation: `CNT_W` = 4, 20 flush cycles → `flush_cnt` = 15 and holds.
